pbit_sweep_scheduler: RTL and testbench
=======================================

# pbit_sweep_scheduler

Parameterised update sequencer for a network of p-bits. It issues one-hot per-p-bit update enables in round-robin order, with a programmable settle gap after each update so the fixed-point local-field datapath (qmult/qadd plus clamp) can propagate the new state. It counts completed Gibbs sweeps, flags a sample-ready point at the end of each sweep, and supports fixed-length and free-running modes. It replaces hard-coded per-design enable sequencing and drives the `en` inputs of the `pbit` instances.

## Interface
- NUM_PBITS, 3, number of p-bits sequenced (≥2)
- SETTLE, 2, idle cycles after each enable pulse (≥0)
- SWEEP_W, 16, width of the sweep counter and sweep target
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- start  in  1  begin a run; sampled only in IDLE
- stop  in  1  request abort; sampled only while busy
- num_sweeps  in  SWEEP_W  sweep target, latched on an accepted start; 0 = free-run
- en  out  NUM_PBITS  one-hot update enable; bit i drives p-bit i
- busy  out  1  run in progress
- sample_valid  out  1  one-cycle pulse: a sweep completed and all p-bit states are settled
- done  out  1  one-cycle pulse: the target sweep count was reached
- sweep_count  out  SWEEP_W  number of completed sweeps in the current or last run

## Operation
- States: IDLE, FIRE, SETTLE. Registers: idx (clog2(NUM_PBITS)), settle counter (clog2(SETTLE+1)), target, stop_pending.
- IDLE: en=0, busy=0. If start=1 and stop=0: latch target=num_sweeps, clear sweep_count and stop_pending, set idx=0, go to FIRE. start and stop high together in IDLE: no action.
- FIRE: en=one-hot(idx) for exactly one cycle. Go to SETTLE if SETTLE>0, otherwise take the advance step.
- SETTLE: en=0 for exactly SETTLE cycles, then take the advance step.
- Advance step (end of each p-bit period):
  - If idx==NUM_PBITS-1, the sweep is complete. Increment sweep_count (modulo 2^SWEEP_W) and pulse sample_valid. If target≠0 and the new count equals target: pulse done and go to IDLE.
  - If stop_pending: go to IDLE with no done pulse. A sweep that completes at this same step still increments the count and pulses sample_valid.
  - Otherwise set idx to idx+1, wrapping to 0 after NUM_PBITS-1, and go to FIRE.
- stop high in any busy cycle sets stop_pending. The abort never truncates a settle window; it takes effect at the next advance step.
- start while busy: ignored. num_sweeps changes while busy: ignored.
- en is never multi-hot. en is all-zero outside FIRE.
- sweep_count holds its value after done or abort until the next accepted start.

## Timing
- Reset: en=0, busy=0, sample_valid=0, done=0, sweep_count=0, state IDLE. RST asserted mid-run takes effect at the next edge, with the same values.
- All outputs are registered.
- start accepted at the edge ending cycle 0. en=one-hot(0) and busy=1 in cycle 1.
- Period P = 1+SETTLE cycles. Sweep length = NUM_PBITS·P.
- p-bit i of sweep s (s from 0) fires in cycle 1 + s·NUM_PBITS·P + i·P.
- sample_valid for sweep s is high in cycle 1 + (s+1)·NUM_PBITS·P. That is the same cycle as the first FIRE of the next sweep, or the done cycle.
- done for the final sweep: done=1 and busy=0 in the same cycle as that sweep's sample_valid. A new start is accepted in that cycle.
- Abort: busy=0 in the cycle after the current period's last cycle.

## Test plan
- Defaults, num_sweeps=2. Required:
  - en = 001 @1, 010 @4, 100 @7, 001 @10, 010 @13, 100 @16, 0 elsewhere.
  - sample_valid @10 and @19.
  - done @19; busy high in cycles 1–18; sweep_count=2.
- Defaults, num_sweeps=0 (free-run), stop pulsed in cycle 5. Required: en=010 @4, no en after it, busy=0 @7, done never asserted, sweep_count=0.
- NUM_PBITS=4, SETTLE=0, num_sweeps=1. Required: en=0001, 0010, 0100, 1000 in cycles 1–4; sample_valid=done=1 @5; busy=0 @5.
- Defaults, RST in cycle 4 (en=010). Required in cycle 5: en=0, busy=0, sweep_count=0. A later start restarts from p-bit 0.
- start held high during a run, and start+stop together in IDLE. Required: both ignored; en sequence unchanged and no run launched.
- SWEEP_W=2, free-run, defaults. Required: sweep_count goes 1, 2, 3, 0, 1 at successive sample_valid pulses; done never asserted.

Source files
------------

// File: rtl/pbit_sweep_scheduler.sv
// pbit_sweep_scheduler
//   Round-robin update sequencer for a p-bit network. Fires a one-hot enable
//   for each p-bit in turn, then holds all enables low for SETTLE cycles so the
//   local-field datapath can absorb the new state before the next update.
//   Counts completed sweeps, pulses sample_valid at each sweep boundary, and
//   runs either for num_sweeps sweeps or free-running (num_sweeps == 0) until
//   stopped.
//
// Ports
//   CLK, RST      clock; synchronous active-high reset
//   start         begin a run (sampled only when idle; ignored if stop is high)
//   stop          abort request (sampled only while busy; honoured at the end
//                 of the current p-bit period)
//   num_sweeps    sweep target latched on an accepted start; 0 = free-run
//   en            one-hot update enable, bit i drives p-bit i
//   busy          run in progress
//   sample_valid  one-cycle pulse: a sweep completed, all states settled
//   done          one-cycle pulse: the target sweep count was reached
//   sweep_count   completed sweeps in the current or last run
module pbit_sweep_scheduler #(
    parameter int NUM_PBITS = 3,
    parameter int SETTLE    = 2,
    parameter int SWEEP_W   = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic                 stop,
    input  logic [SWEEP_W-1:0]   num_sweeps,
    output logic [NUM_PBITS-1:0] en,
    output logic                 busy,
    output logic                 sample_valid,
    output logic                 done,
    output logic [SWEEP_W-1:0]   sweep_count
);

    localparam int IW = (NUM_PBITS > 1) ? $clog2(NUM_PBITS) : 1;
    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FIRE   = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PBITS - 1);
    localparam logic [CW-1:0] SET_LAST = (SETTLE > 0) ? CW'(SETTLE - 1) : '0;

    logic [1:0]         state;
    logic [IW-1:0]      idx;
    logic [CW-1:0]      scnt;
    logic [SWEEP_W-1:0] target;
    logic               stop_pending;

    logic               adv;
    logic               last;
    logic               fin;
    logic               go_idle;
    logic [SWEEP_W-1:0] cnt_inc;
    logic [IW-1:0]      idx_nxt;

    // Advance happens at the end of each p-bit period: directly out of FIRE
    // when there is no settle gap, otherwise on the last settle cycle.
    always_comb begin
        adv     = ((state == S_FIRE) && (SETTLE == 0)) ||
                  ((state == S_SETTLE) && (scnt == SET_LAST));
        last    = (idx == LAST_IDX);
        cnt_inc = sweep_count + SWEEP_W'(1);
        fin     = last && (target != '0) && (cnt_inc == target);
        // A stop seen in the final cycle of the period still counts as pending.
        go_idle = fin || stop_pending || stop;
        idx_nxt = last ? '0 : idx + IW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= S_IDLE;
            idx          <= '0;
            scnt         <= '0;
            target       <= '0;
            stop_pending <= 1'b0;
            en           <= '0;
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            done         <= 1'b0;
            sweep_count  <= '0;
        end else begin
            en           <= '0;
            sample_valid <= 1'b0;
            done         <= 1'b0;

            if ((state != S_IDLE) && stop)
                stop_pending <= 1'b1;

            if (adv) begin
                if (last) begin
                    sweep_count  <= cnt_inc;
                    sample_valid <= 1'b1;
                end
                if (fin)
                    done <= 1'b1;
                if (go_idle) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end else begin
                    state <= S_FIRE;
                    idx   <= idx_nxt;
                    en    <= NUM_PBITS'(1) << idx_nxt;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !stop) begin
                            target       <= num_sweeps;
                            sweep_count  <= '0;
                            stop_pending <= 1'b0;
                            idx          <= '0;
                            state        <= S_FIRE;
                            en           <= NUM_PBITS'(1);
                            busy         <= 1'b1;
                        end
                    end
                    // Only reached with SETTLE > 0; otherwise FIRE always advances.
                    S_FIRE: begin
                        state <= S_SETTLE;
                        scnt  <= '0;
                    end
                    S_SETTLE: scnt <= scnt + CW'(1);
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pbit_sweep_scheduler.sv
// Self-checking bench for pbit_sweep_scheduler: table-driven vectors against a
// default instance, plus hand-written sequences for a SETTLE=0 / 4-p-bit
// instance and a 2-bit sweep counter wraparound instance.
module tb_pbit_sweep_scheduler;

    logic CLK = 1'b0;
    logic RST;
    logic stop;
    always #5 CLK = ~CLK;

    // default instance: NUM_PBITS=3, SETTLE=2, SWEEP_W=16
    logic        start_a;
    logic [15:0] ns_a;
    logic [2:0]  en_a;
    logic        busy_a, sv_a, done_a;
    logic [15:0] cnt_a;

    // NUM_PBITS=4, SETTLE=0
    logic        start_b;
    logic [15:0] ns_b;
    logic [3:0]  en_b;
    logic        busy_b, sv_b, done_b;
    logic [15:0] cnt_b;

    // SWEEP_W=2
    logic        start_c;
    logic [1:0]  ns_c;
    logic [2:0]  en_c;
    logic        busy_c, sv_c, done_c;
    logic [1:0]  cnt_c;

    pbit_sweep_scheduler dut_a (
        .CLK(CLK), .RST(RST), .start(start_a), .stop(stop), .num_sweeps(ns_a),
        .en(en_a), .busy(busy_a), .sample_valid(sv_a), .done(done_a), .sweep_count(cnt_a)
    );

    pbit_sweep_scheduler #(.NUM_PBITS(4), .SETTLE(0), .SWEEP_W(16)) dut_b (
        .CLK(CLK), .RST(RST), .start(start_b), .stop(stop), .num_sweeps(ns_b),
        .en(en_b), .busy(busy_b), .sample_valid(sv_b), .done(done_b), .sweep_count(cnt_b)
    );

    pbit_sweep_scheduler #(.NUM_PBITS(3), .SETTLE(2), .SWEEP_W(2)) dut_c (
        .CLK(CLK), .RST(RST), .start(start_c), .stop(stop), .num_sweeps(ns_c),
        .en(en_c), .busy(busy_c), .sample_valid(sv_c), .done(done_c), .sweep_count(cnt_c)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        int          cyc;
        logic        rst, start, stp;
        logic [15:0] ns;
        logic [2:0]  en;
        logic        sv, done, busy;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input string name, input int cyc, input logic rst,
                                input logic start, input logic stp, input logic [15:0] ns,
                                input logic [2:0] en, input logic sv, input logic done,
                                input logic busy, input logic [15:0] cnt);
        vec_t v;
        v.name = name; v.cyc = cyc; v.rst = rst; v.start = start; v.stp = stp; v.ns = ns;
        v.en = en; v.sv = sv; v.done = done; v.busy = busy; v.cnt = cnt;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [3:0] eb [7];
        logic [1:0] ec [5];
        int got, dn, cyc;
        logic [2:0] e;

        // run2: two sweeps, start held high through cycle 12 (must be ignored)
        for (int c = 0; c <= 20; c++) begin
            case (c)
                1, 10:   e = 3'b001;
                4, 13:   e = 3'b010;
                7, 16:   e = 3'b100;
                default: e = 3'b000;
            endcase
            add("run2", c, 1'b0, c <= 12, 1'b0, 16'd2, e, (c == 10) || (c == 19),
                c == 19, (c >= 1) && (c <= 18), (c < 10) ? 16'd0 : (c < 19) ? 16'd1 : 16'd2);
        end
        // start+stop together while idle: no run, count from run2 kept
        for (int c = 0; c <= 3; c++)
            add("startstop", c, 1'b0, c == 0, c == 0, 16'd1, 3'b000, 1'b0, 1'b0, 1'b0, 16'd2);
        // free-run aborted by stop in cycle 5
        for (int c = 0; c <= 10; c++)
            add("abort", c, 1'b0, c == 0, c == 5, 16'd0,
                (c == 1) ? 3'b001 : (c == 4) ? 3'b010 : 3'b000, 1'b0, 1'b0,
                (c >= 1) && (c <= 6), (c == 0) ? 16'd2 : 16'd0);
        // RST in cycle 4, then restart from p-bit 0
        for (int c = 0; c <= 8; c++)
            add("rst", c, c == 4, (c == 0) || (c == 6), 1'b0, 16'd2,
                (c == 1 || c == 7) ? 3'b001 : (c == 4) ? 3'b010 : 3'b000, 1'b0, 1'b0,
                ((c >= 1) && (c <= 4)) || (c >= 7), 16'd0);

        RST = 1'b1; stop = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        ns_a = '0; ns_b = '0; ns_c = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_en", 0, 32'(en_a), 0);
        chk("rst_busy", 0, 32'(busy_a), 0);
        chk("rst_sv", 0, 32'(sv_a), 0);
        chk("rst_done", 0, 32'(done_a), 0);
        chk("rst_cnt", 0, 32'(cnt_a), 0);
        chk("rst_b_busy", 0, 32'(busy_b), 0);
        chk("rst_c_cnt", 0, 32'(cnt_c), 0);
        @(posedge CLK); #1 RST = 1'b0;

        foreach (tbl[i]) begin
            @(posedge CLK); #1;
            RST = tbl[i].rst; start_a = tbl[i].start; stop = tbl[i].stp; ns_a = tbl[i].ns;
            @(negedge CLK);
            chk({tbl[i].name, "_en"},   tbl[i].cyc, 32'(en_a),   32'(tbl[i].en));
            chk({tbl[i].name, "_sv"},   tbl[i].cyc, 32'(sv_a),   32'(tbl[i].sv));
            chk({tbl[i].name, "_done"}, tbl[i].cyc, 32'(done_a), 32'(tbl[i].done));
            chk({tbl[i].name, "_busy"}, tbl[i].cyc, 32'(busy_a), 32'(tbl[i].busy));
            chk({tbl[i].name, "_cnt"},  tbl[i].cyc, 32'(cnt_a),  32'(tbl[i].cnt));
        end
        @(posedge CLK); #1;
        RST = 1'b0; start_a = 1'b0; stop = 1'b0;

        // NUM_PBITS=4, SETTLE=0, one sweep
        eb = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
        start_b = 1'b1; ns_b = 16'd1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge CLK); #1 start_b = 1'b0;
            @(negedge CLK);
            chk("b_en",   c, 32'(en_b),   32'(eb[c]));
            chk("b_sv",   c, 32'(sv_b),   32'(c == 5));
            chk("b_done", c, 32'(done_b), 32'(c == 5));
            chk("b_busy", c, 32'(busy_b), 32'((c >= 1) && (c <= 4)));
        end
        chk("b_cnt", 6, 32'(cnt_b), 1);

        // SWEEP_W=2 free-run: count wraps 1,2,3,0,1
        ec = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        @(posedge CLK); #1 start_c = 1'b1; ns_c = 2'd0;
        got = 0; dn = 0; cyc = 0;
        while (got < 5 && cyc < 100) begin
            @(posedge CLK); #1 start_c = 1'b0;
            @(negedge CLK);
            cyc++;
            if (done_c) dn++;
            if (sv_c) begin
                chk("c_cnt", cyc, 32'(cnt_c), 32'(ec[got]));
                chk("c_sv_cycle", cyc, 32'(cyc), 32'(10 + 9 * got));
                got++;
            end
        end
        chk("c_pulses", cyc, 32'(got), 5);
        chk("c_done_never", cyc, 32'(dn), 0);
        @(posedge CLK); #1 stop = 1'b1;
        @(posedge CLK); #1 stop = 1'b0;
        cyc = 0;
        while (busy_c && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        chk("c_stop_idle", cyc, 32'(busy_c), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
